// File: rtl/amdf_pkg.sv
// rtl/amdf_pkg.sv - shared state type, width helpers and abs-diff for the AMDF engine
package amdf_pkg;

  typedef enum logic [1:0] {LOAD, ACC, DIV, OUT} amdf_state_t;

  // Abs-diff operands are carried at a fixed width wide enough for W <= 32
  localparam int ABS_W = 33;

  function automatic int sum_width(input int w, input int n);
    return w + 1 + $clog2(n);
  endfunction

  function automatic int lag_width(input int l_max);
    return $clog2(l_max + 1);
  endfunction

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    logic [ABS_W:0] d;
    d = {a[ABS_W-1], a} - {b[ABS_W-1], b};
    return d[ABS_W] ? ABS_W'(-d) : d[ABS_W-1:0];
  endfunction

endpackage

// File: rtl/amdf_divider.sv
// rtl/amdf_divider.sv - unsigned restoring divider, fixed SW-cycle latency, one-cycle done pulse
module amdf_divider #(
  parameter int SW = 21
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [SW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          done,
  output logic [SW-1:0] quotient
);

  localparam int CW = $clog2(SW + 1);

  logic [SW-1:0] rem;
  logic [CW-1:0] cnt;
  logic          running;
  logic [SW:0]   rem_sh;
  logic [SW+1:0] trial;

  // Dividend bits shift out of the quotient register as quotient bits shift in
  assign rem_sh = {rem, quotient[SW-1]};
  assign trial  = {1'b0, rem_sh} - {2'b00, divisor};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= '0;
        quotient <= dividend;
        cnt      <= CW'(SW);
        running  <= 1'b1;
      end else if (running) begin
        if (trial[SW+1]) begin
          rem      <= rem_sh[SW-1:0];
          quotient <= {quotient[SW-2:0], 1'b0};
        end else begin
          rem      <= trial[SW-1:0];
          quotient <= {quotient[SW-2:0], 1'b1};
        end
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/amdf_stream.sv
// rtl/amdf_stream.sv - streaming shared-datapath AMDF pitch engine; AMDF_NORM_EN enables per-lag normalisation
module amdf_stream
  import amdf_pkg::*;
#(
  parameter  int W         = 16,
  parameter  int N         = 12,
  parameter  int L_MIN     = 4,
  parameter  int L_MAX     = 8,
  parameter  int SIGNED_IN = 0,
  localparam int SW        = sum_width(W, N),
  localparam int LW        = lag_width(L_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_sample,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] out_lag,
  output logic [SW-1:0] out_value,
  output logic          out_last,
  output logic          best_valid,
  output logic [LW-1:0] best_lag,
  output logic [SW-1:0] best_value,
  output logic          busy
);

  localparam int IW = $clog2(N);

  amdf_state_t   state, state_nxt;
  logic [W-1:0]  sample_mem [N];
  logic [IW-1:0] cnt, i_idx, j_idx, last_i;
  logic [LW-1:0] k, trk_lag;
  logic [SW-1:0] sum, sum_nxt, trk_val;
  logic [W-1:0]  xa, xb;
  logic [ABS_W-1:0] xa_ext, xb_ext;
  logic [W:0]    absd;
  logic          acc_last, lag_last, take_in, new_min;

  assign j_idx    = i_idx + IW'(k);
  assign last_i   = IW'(N - 1) - IW'(k);
  assign xa       = sample_mem[i_idx];
  assign xb       = sample_mem[j_idx];
  assign xa_ext   = (SIGNED_IN != 0) ? {{(ABS_W-W){xa[W-1]}}, xa} : {{(ABS_W-W){1'b0}}, xa};
  assign xb_ext   = (SIGNED_IN != 0) ? {{(ABS_W-W){xb[W-1]}}, xb} : {{(ABS_W-W){1'b0}}, xb};
  assign absd     = (W+1)'(abs_diff(xa_ext, xb_ext));
  assign sum_nxt  = sum + SW'(absd);
  assign acc_last = (i_idx == last_i);
  assign lag_last = (k == LW'(L_MAX));
  assign take_in  = (state == LOAD) && in_valid;
  // First lag always seeds the tracker; strict less-than keeps the smaller lag on ties
  assign new_min  = (k == LW'(L_MIN)) || (out_value < trk_val);

`ifdef AMDF_NORM_EN
  logic          div_start, div_done;
  logic [SW-1:0] div_q;

  amdf_divider #(.SW(SW)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (sum_nxt),
    .divisor  (SW'(N) - SW'(k)),
    .done     (div_done),
    .quotient (div_q)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef AMDF_NORM_EN
    div_start = 1'b0;
`endif
    in_ready  = (state == LOAD);
    busy      = (state != LOAD);
    out_valid = (state == OUT);
    out_last  = (state == OUT) && lag_last;
    case (state)
      LOAD: if (in_valid && cnt == IW'(N - 1)) state_nxt = ACC;
      ACC: begin
        if (acc_last) begin
`ifdef AMDF_NORM_EN
          state_nxt = DIV;
          div_start = 1'b1;
`else
          state_nxt = OUT;
`endif
        end
      end
      DIV: begin
`ifdef AMDF_NORM_EN
        if (div_done) state_nxt = OUT;
`else
        state_nxt = OUT;
`endif
      end
      OUT: if (out_ready) state_nxt = lag_last ? LOAD : ACC;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (take_in) sample_mem[cnt] <= in_sample;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      k          <= LW'(L_MIN);
      i_idx      <= '0;
      sum        <= '0;
      out_lag    <= '0;
      out_value  <= '0;
      trk_val    <= '0;
      trk_lag    <= '0;
      best_lag   <= '0;
      best_value <= '0;
      best_valid <= 1'b0;
    end else begin
      best_valid <= 1'b0;
      case (state)
        LOAD: if (in_valid) cnt <= (cnt == IW'(N - 1)) ? '0 : cnt + 1'b1;
        ACC: begin
          sum   <= sum_nxt;
          i_idx <= i_idx + 1'b1;
          if (acc_last) begin
            out_lag <= k;
`ifndef AMDF_NORM_EN
            out_value <= sum_nxt;
`endif
          end
        end
        DIV: begin
`ifdef AMDF_NORM_EN
          if (div_done) out_value <= div_q;
`endif
        end
        OUT: begin
          if (out_ready) begin
            if (new_min) begin
              trk_val <= out_value;
              trk_lag <= k;
            end
            i_idx <= '0;
            sum   <= '0;
            if (lag_last) begin
              k          <= LW'(L_MIN);
              best_valid <= 1'b1;
              best_lag   <= new_min ? k : trk_lag;
              best_value <= new_min ? out_value : trk_val;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
